fracnet_mul_share_arb: RTL and testbench

- Shares one unsigned 11x5->16 DSP48 multiplier, the existing FracNet_mul_mul_1ncg instance, among NUM_REQ requesters.
- Requesters are the BN/scale and quantisation lanes of a FracNet conv tile.
- Round-robin arbitration, valid/ready handshake on both request and response sides, two-stage pipeline: operand register then product register.
- Each product is returned only to the requester that issued it.

---
 rtl/fracnet_mul_arb_pkg.sv | 25 ++
 rtl/FracNet_mul_mul_1ncg.sv | 14 +
 rtl/fracnet_rr_arbiter.sv | 45 ++++
 rtl/fracnet_mul_share_arb.sv | 148 ++++++++++++++
 tb/tb_fracnet_mul_share_arb.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fracnet_mul_arb_pkg.sv
// Shared definitions for the FracNet multiplier-sharing arbiter.
// Holds default widths, the id-width helper and the default-configuration stage layout.
package fracnet_mul_arb_pkg;

    localparam int NUM_REQ_DEF = 4;
    localparam int A_WIDTH_DEF = 11;
    localparam int B_WIDTH_DEF = 5;
    localparam int P_WIDTH_DEF = A_WIDTH_DEF + B_WIDTH_DEF;
    localparam int STAT_WIDTH  = 32;

    // Requester id width; a single-requester build still needs one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int ID_WIDTH_DEF = id_width(NUM_REQ_DEF);

    typedef struct packed {
        logic                    valid;
        logic [ID_WIDTH_DEF-1:0] id;
        logic [A_WIDTH_DEF-1:0]  a;
        logic [B_WIDTH_DEF-1:0]  b;
    } stage_t;

endpackage

// File: rtl/FracNet_mul_mul_1ncg.sv
// Unsigned combinational multiplier core shared by the FracNet conv tile lanes.
module FracNet_mul_mul_1ncg #(
    parameter int din0_WIDTH = 11,
    parameter int din1_WIDTH = 5,
    parameter int dout_WIDTH = 16
) (
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic [dout_WIDTH-1:0] dout
);

    assign dout = dout_WIDTH'(din0) * dout_WIDTH'(din1);

endmodule

// File: rtl/fracnet_rr_arbiter.sv
// Combinational round-robin arbiter: search starts at ptr, grant gated by en.
module fracnet_rr_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_WIDTH-1:0] ptr,
    input  logic                en,
    output logic [NUM_REQ-1:0]  gnt,
    output logic [ID_WIDTH-1:0] winner
);

    logic [2*NUM_REQ-1:0] dbl_s;
    logic [NUM_REQ-1:0]   rot_s;
    logic                 found_s;
    int                   sum_s;

    // Rotate requests so bit 0 is the requester at ptr, then pick the lowest set bit.
    always_comb begin
        dbl_s   = {req, req} >> ptr;
        rot_s   = dbl_s[NUM_REQ-1:0];
        found_s = 1'b0;
        sum_s   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found_s && rot_s[k]) begin
                found_s = 1'b1;
                sum_s   = int'(ptr) + k;
            end else begin
                found_s = found_s;
            end
        end
        if (sum_s >= NUM_REQ) begin
            sum_s = sum_s - NUM_REQ;
        end else begin
            sum_s = sum_s;
        end
        winner = ID_WIDTH'(sum_s);
        if (en && found_s) begin
            gnt = NUM_REQ'(1) << winner;
        end else begin
            gnt = '0;
        end
    end

endmodule

// File: rtl/fracnet_mul_share_arb.sv
// Shares one 11x5 unsigned multiplier among NUM_REQ lanes through a two-stage in-order pipe.
// Optional per-requester saturating grant counters are built when MUL_ARB_STATS_EN is defined.
module fracnet_mul_share_arb
    import fracnet_mul_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int A_WIDTH = A_WIDTH_DEF,
    parameter int B_WIDTH = B_WIDTH_DEF,
    parameter int P_WIDTH = A_WIDTH + B_WIDTH
) (
    input  logic                          ap_clk,
    input  logic                          ap_rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*A_WIDTH-1:0]    req_a,
    input  logic [NUM_REQ*B_WIDTH-1:0]    req_b,
    output logic [NUM_REQ-1:0]            rsp_valid,
    input  logic [NUM_REQ-1:0]            rsp_ready,
    output logic [P_WIDTH-1:0]            rsp_p,
    output logic                          busy,
    output logic [NUM_REQ*STAT_WIDTH-1:0] stat_grants
);

    localparam int ID_WIDTH = id_width(NUM_REQ);

    typedef struct packed {
        logic                valid;
        logic [ID_WIDTH-1:0] id;
        logic [A_WIDTH-1:0]  a;
        logic [B_WIDTH-1:0]  b;
    } s1_stage_t;

    s1_stage_t           s1_r;
    logic                s2_valid_r;
    logic [ID_WIDTH-1:0] s2_id_r;
    logic [P_WIDTH-1:0]  s2_p_r;
    logic [ID_WIDTH-1:0] ptr_r;

    logic                adv1_s;
    logic                adv2_s;
    logic                fire_s;
    logic [NUM_REQ-1:0]  gnt_s;
    logic [ID_WIDTH-1:0] win_s;
    logic [P_WIDTH-1:0]  mul_p_s;

    // Stage advance: only the owning requester's rsp_ready can drain S2.
    always_comb begin
        adv2_s = !s2_valid_r || rsp_ready[s2_id_r];
        adv1_s = !s1_r.valid || adv2_s;
    end

    fracnet_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_WIDTH(ID_WIDTH)
    ) u_arb (
        .req   (req_valid),
        .ptr   (ptr_r),
        .en    (adv1_s),
        .gnt   (gnt_s),
        .winner(win_s)
    );

    assign req_ready = gnt_s;
    assign fire_s    = |gnt_s;

    FracNet_mul_mul_1ncg #(
        .din0_WIDTH(A_WIDTH),
        .din1_WIDTH(B_WIDTH),
        .dout_WIDTH(P_WIDTH)
    ) u_mul (
        .din0(s1_r.a),
        .din1(s1_r.b),
        .dout(mul_p_s)
    );

    // Operand stage, product stage and round-robin pointer.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            s1_r       <= '0;
            s2_valid_r <= 1'b0;
            s2_id_r    <= '0;
            s2_p_r     <= '0;
            ptr_r      <= '0;
        end else begin
            if (adv1_s) begin
                s1_r.valid <= fire_s;
                if (fire_s) begin
                    s1_r.id <= win_s;
                    s1_r.a  <= req_a[int'(win_s)*A_WIDTH +: A_WIDTH];
                    s1_r.b  <= req_b[int'(win_s)*B_WIDTH +: B_WIDTH];
                end
            end
            if (adv2_s) begin
                s2_valid_r <= s1_r.valid;
                if (s1_r.valid) begin
                    s2_id_r <= s1_r.id;
                    s2_p_r  <= mul_p_s;
                end
            end
            if (fire_s) begin
                ptr_r <= (win_s == ID_WIDTH'(NUM_REQ - 1)) ? '0 : win_s + ID_WIDTH'(1);
            end
        end
    end

    // One-hot response valid decoded from the S2 owner.
    always_comb begin
        rsp_valid = '0;
        if (s2_valid_r) begin
            rsp_valid[s2_id_r] = 1'b1;
        end else begin
            rsp_valid = '0;
        end
    end

    assign rsp_p = s2_p_r;
    assign busy  = s1_r.valid | s2_valid_r;

`ifdef MUL_ARB_STATS_EN
    logic [STAT_WIDTH-1:0] grant_cnt_r [NUM_REQ];

    // Saturating per-requester grant counters, cleared only by reset.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                grant_cnt_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (gnt_s[i] && (grant_cnt_r[i] != '1)) begin
                    grant_cnt_r[i] <= grant_cnt_r[i] + STAT_WIDTH'(1);
                end
            end
        end
    end

    // Pack counters onto the flat status bus.
    always_comb begin
        stat_grants = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            stat_grants[i*STAT_WIDTH +: STAT_WIDTH] = grant_cnt_r[i];
        end
    end
`else
    assign stat_grants = '0;
`endif

endmodule

// File: tb/tb_fracnet_mul_share_arb.sv
// Self-checking bench: directed scenarios plus random traffic against an in-order queue model.
module tb_fracnet_mul_share_arb;

    localparam int N  = 4;
    localparam int AW = 11;
    localparam int BW = 5;
    localparam int PW = 16;

    logic            ap_clk = 1'b0;
    logic            ap_rst_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*AW-1:0] req_a;
    logic [N*BW-1:0] req_b;
    logic [N-1:0]    rsp_valid;
    logic [N-1:0]    rsp_ready;
    logic [PW-1:0]   rsp_p;
    logic            busy;
    logic [N*32-1:0] stat_grants;

    fracnet_mul_share_arb dut (
        .ap_clk     (ap_clk),
        .ap_rst_n   (ap_rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_p      (rsp_p),
        .busy       (busy),
        .stat_grants(stat_grants)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct {
        int id;
        int p;
        int t;
    } ent_t;

    ent_t          q[$];
    int            glog[$];
    int            ptr_m;
    int            cycle;
    int            gcnt[N];
    int            checks;
    int            failures;
    logic [N-1:0]  cap_ready;
    logic [N-1:0]  cap_rsp_valid;
    logic [PW-1:0] cap_rsp_p;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int i, input int a, input int b);
        req_a[i*AW +: AW] = AW'(a);
        req_b[i*BW +: BW] = BW'(b);
    endtask

    task automatic rand_ops();
        for (int i = 0; i < N; i++) set_op(i, int'($urandom_range(0, 2047)), int'($urandom_range(0, 31)));
    endtask

    // One clock: compare against the model mid-cycle, then commit the model at the edge.
    task automatic cyc();
        int   w;
        bit   any, vis, pop, fire;
        logic [N-1:0] exp_rv, exp_ready;
        #3;
        cap_ready     = req_ready;
        cap_rsp_valid = rsp_valid;
        cap_rsp_p     = rsp_p;
        vis    = (q.size() > 0) && (cycle >= q[0].t + 2);
        exp_rv = vis ? (4'b0001 << q[0].id) : 4'b0000;
        check("rsp_valid", rsp_valid, exp_rv);
        if (vis) check("rsp_p", rsp_p, q[0].p);
        check("busy", busy, q.size() > 0);
        pop = vis && rsp_ready[q[0].id];
        any = 1'b0;
        w   = 0;
        for (int k = 0; k < N; k++) begin
            int c;
            c = (ptr_m + k) % N;
            if (!any && req_valid[c]) begin
                any = 1'b1;
                w   = c;
            end
        end
        fire      = any && (q.size() < 2 || pop);
        exp_ready = fire ? (4'b0001 << w) : 4'b0000;
        check("req_ready", req_ready, exp_ready);
        @(posedge ap_clk);
        if (pop) void'(q.pop_front());
        if (fire) begin
            q.push_back('{w, int'(req_a[w*AW +: AW]) * int'(req_b[w*BW +: BW]), cycle});
            ptr_m = (w + 1) % N;
            gcnt[w]++;
            glog.push_back(w);
        end
        cycle++;
        #1;
    endtask

    task automatic check_stats(input string tag);
`ifdef MUL_ARB_STATS_EN
        for (int i = 0; i < N; i++) check(tag, stat_grants[i*32 +: 32], gcnt[i]);
`else
        check(tag, |stat_grants, 1'b0);
`endif
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        ptr_m     = 0;
        cycle     = 0;
        req_valid = '0;
        rsp_ready = '0;
        req_a     = '0;
        req_b     = '0;
        for (int i = 0; i < N; i++) gcnt[i] = 0;
        ap_rst_n = 1'b1;
        #1 ap_rst_n = 1'b0;
        repeat (2) @(posedge ap_clk);
        #1;
        check("rst_rsp_valid", rsp_valid, 4'b0000);
        check("rst_rsp_p", rsp_p, 16'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_req_ready", req_ready, 4'b0000);
        check_stats("rst_stats");
        @(negedge ap_clk) ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;

        // Single request: latency two cycles after the handshake.
        rsp_ready = 4'b1111;
        set_op(0, 2047, 31);
        req_valid = 4'b0001;
        cyc();
        check("single_grant", cap_ready, 4'b0001);
        req_valid = 4'b0000;
        cyc();
        check("single_early", cap_rsp_valid, 4'b0000);
        cyc();
        check("single_valid", cap_rsp_valid, 4'b0001);
        check("single_p", cap_rsp_p, 16'd63457);

        // All requesters continuously valid with full response readiness.
        req_valid = 4'b1111;
        for (int n = 0; n < 12; n++) begin
            rand_ops();
            cyc();
        end
        req_valid = 4'b0000;
        repeat (3) cyc();

        // Pointer parked at 2, then a sparse request mask.
        glog.delete();
        req_valid = 4'b0010;
        cyc();
        req_valid = 4'b1011;
        repeat (3) cyc();
        req_valid = 4'b0000;
        check("rr_count", glog.size(), 4);
        check("rr_first", glog[1], 3);
        check("rr_second", glog[2], 0);
        check("rr_third", glog[3], 1);
        repeat (3) cyc();

        // Backpressure on requester 1 with both stages full.
        set_op(1, 123, 10);
        rsp_ready = 4'b1101;
        req_valid = 4'b0010;
        cyc();
        set_op(2, 77, 3);
        req_valid = 4'b0100;
        cyc();
        set_op(0, 555, 17);
        req_valid = 4'b0001;
        for (int n = 0; n < 5; n++) begin
            cyc();
            check("bp_hold_p", cap_rsp_p, 16'd1230);
            check("bp_hold_valid", cap_rsp_valid, 4'b0010);
            check("bp_no_ready", cap_ready, 4'b0000);
        end
        rsp_ready = 4'b1111;
        cyc();
        req_valid = 4'b0000;
        repeat (4) cyc();

        // Zero and unit operands from one requester, back to back.
        req_valid = 4'b0100;
        set_op(2, 0, 31);
        cyc();
        set_op(2, 1500, 0);
        cyc();
        set_op(2, 1, 1);
        cyc();
        req_valid = 4'b0000;
        check("zero_a_p", cap_rsp_p, 16'd0);
        check("zero_a_valid", cap_rsp_valid, 4'b0100);
        cyc();
        check("zero_b_p", cap_rsp_p, 16'd0);
        cyc();
        check("unit_p", cap_rsp_p, 16'd1);
        cyc();

        // Random traffic and random response backpressure.
        for (int n = 0; n < 400; n++) begin
            req_valid = N'($urandom_range(0, 15));
            rsp_ready = N'($urandom_range(0, 15)) | N'($urandom_range(0, 15));
            rand_ops();
            cyc();
        end
        req_valid = 4'b0000;
        rsp_ready = 4'b1111;
        repeat (4) cyc();
        check_stats("stats_run");

        // Reset with both stages occupied.
        rsp_ready = 4'b0000;
        req_valid = 4'b0001;
        rand_ops();
        repeat (2) cyc();
        req_valid = 4'b0000;
        #1;
        check("pre_rst_busy", busy, 1'b1);
        ap_rst_n = 1'b0;
        #1;
        check("mid_rst_valid", rsp_valid, 4'b0000);
        check("mid_rst_p", rsp_p, 16'd0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_ready", req_ready, 4'b0000);
        q.delete();
        ptr_m = 0;
        for (int i = 0; i < N; i++) gcnt[i] = 0;
        check_stats("mid_rst_stats");
        @(negedge ap_clk) ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;
        rsp_ready = 4'b1111;
        req_valid = 4'b1111;
        rand_ops();
        cyc();
        check("post_rst_grant", cap_ready, 4'b0001);
        repeat (5) begin
            rand_ops();
            cyc();
        end
        req_valid = 4'b0000;
        repeat (4) cyc();
        check_stats("stats_end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
